flush_sequencer: RTL and testbench
==================================

FLUSH_SEQUENCER -- requirements
Module: flush_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent cache flush request/ack channels (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 512, maximum FLUSH-state cycles before forced completion (>=2).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  clock, all state on rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 fence_i_i  in  1  fence.i commit pulse; flush icache, all data channels and pipeline.
REQ-007 fence_i  in  1  data fence commit pulse; flush all data channels and pipeline.
REQ-008 sfence_vma_i  in  1  sfence.vma commit pulse; flush TLB and pipeline.
REQ-009 flush_csr_i  in  1  CSR side-effect pulse; pipeline flush only.
REQ-010 flush_ack_i  in  NUM_CH  per-channel flush-complete pulse.
REQ-011 flush_req_o  out  NUM_CH  per-channel flush request, level, held until acked.
REQ-012 ack_pending_o  out  NUM_CH  channels still awaiting ack.
REQ-013 halt_o  out  1  stall commit while sequence active.
REQ-014 busy_o  out  1  state != IDLE.
REQ-015 flush_pipe_o, set_pc_commit_o, flush_icache_o, flush_tlb_o  out  1 each  single-cycle completion pulses.
REQ-016 timeout_o  out  1  pulse in FINISH when completion was forced.

Function
REQ-017 SHALL implement FSM states IDLE, FLUSH, FINISH.
REQ-018 IDLE: any request pulse SHALL capture kind flags (icache, dcache, tlb), OR-ing simultaneous requests.
REQ-019 IDLE with fence_i_i or fence_i SHALL go to FLUSH next cycle with pending = all ones, timer = 0.
REQ-020 IDLE with only sfence_vma_i and/or flush_csr_i SHALL go to FINISH next cycle; no flush_req_o asserted.
REQ-021 FLUSH: flush_req_o SHALL equal pending; ack on channel k SHALL clear pending[k] next cycle; acks on non-pending channels and in other states SHALL be ignored.
REQ-022 FLUSH: when (pending & ~flush_ack_i) == 0, SHALL go to FINISH next cycle.
REQ-023 FLUSH: timer SHALL increment each non-completing cycle; at timer == TIMEOUT-1 without completion SHALL clear pending, set timeout flag, go to FINISH (FLUSH lasts exactly TIMEOUT cycles).
REQ-024 Completion and timeout in the same cycle SHALL count as completion (timeout flag clear).
REQ-025 FINISH (one cycle): flush_pipe_o=1, set_pc_commit_o=1, flush_icache_o=icache flag, flush_tlb_o=tlb flag, timeout_o=timeout flag; then IDLE with flags cleared.
REQ-026 halt_o and busy_o SHALL be 1 in FLUSH and FINISH, 0 in IDLE.
REQ-027 Requests arriving in FLUSH or FINISH SHALL be ignored (commit halted upstream).
REQ-028 All outputs SHALL be registered-state decodes; no input-to-output combinational path.

Reset
REQ-029 rst_i SHALL force IDLE, pending=0, timer=0, flags=0 immediately; all outputs 0 during and after reset.
REQ-030 Reset mid-FLUSH SHALL abandon the sequence with no FINISH pulses.

Structure
REQ-031 flush_seq_pkg SHALL hold state enum and packed kind-flag struct.
REQ-032 Sub-module flush_ack_tracker SHALL hold pending mask, timer, completion/timeout detection.

Verification
REQ-033 sfence_vma_i pulse cycle N -> cycle N+1 flush_pipe_o=flush_tlb_o=set_pc_commit_o=1, no flush_req_o, IDLE at N+2.
REQ-034 NUM_CH=2, fence_i_i cycle N, ack 2'b01 at N+2, 2'b10 at N+4 -> flush_req_o 11,11,10,10 over N+1..N+4, FINISH with flush_icache_o=1 at N+5.
REQ-035 fence_i, no acks, TIMEOUT=8 -> flush_req_o high N+1..N+8, FINISH at N+9 with timeout_o=1.
REQ-036 fence_i and sfence_vma_i same cycle, both acks at N+1 -> FINISH at N+2 with flush_tlb_o=1, flush_icache_o=0.
REQ-037 rst_i asserted during FLUSH -> all outputs 0 immediately; no FINISH pulses after release.

Source files
------------

// File: rtl/flush_seq_pkg.sv
// Shared types for the flush sequencer.
//   state_e : sequencer FSM state encoding
//   kind_t  : packed flags naming which structures the current sequence flushes
package flush_seq_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFlush  = 2'd1,
    StFinish = 2'd2
  } state_e;

  typedef struct packed {
    logic icache;
    logic dcache;
    logic tlb;
  } kind_t;

  localparam kind_t KindNone = '0;

  // Simultaneous requests are OR-ed: fence.i implies a data flush as well.
  function automatic kind_t decode_kind(logic fence_i_req, logic fence_req, logic sfence_req);
    kind_t k;
    k.icache = fence_i_req;
    k.dcache = fence_i_req | fence_req;
    k.tlb    = sfence_req;
    return k;
  endfunction

  // Width of a counter that must reach limit-1; never narrower than one bit.
  function automatic int unsigned timer_width(int unsigned limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/flush_ack_tracker.sv
// Per-channel ack bookkeeping for a flush sequence.
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   start_i       : load pending = all ones, timer = 0
//   active_i      : sequencer is in the FLUSH state
//   flush_ack_i   : per-channel completion pulses
//   pending_o     : channels still awaiting an ack (registered)
//   done_o        : sequence ends this cycle (all acked, or forced)
//   forced_o      : sequence ends this cycle by timeout without completion
module flush_ack_tracker
  import flush_seq_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned TIMEOUT = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              active_i,
  input  logic [NUM_CH-1:0] flush_ack_i,
  output logic [NUM_CH-1:0] pending_o,
  output logic              done_o,
  output logic              forced_o
);

  localparam int unsigned TW = timer_width(TIMEOUT);
  typedef logic [TW-1:0] timer_t;
  localparam timer_t TimerLast = timer_t'(TIMEOUT - 1);

  logic [NUM_CH-1:0] pending_q, pending_d, remaining;
  timer_t            timer_q, timer_d;
  logic              complete, expired;

  // Acks on channels that are no longer pending fall out of the AND.
  assign remaining = pending_q & ~flush_ack_i;
  assign complete  = active_i && (remaining == '0);
  // Completion wins over a coincident timeout.
  assign expired   = active_i && !complete && (timer_q == TimerLast);

  assign pending_o = pending_q;
  assign done_o    = complete || expired;
  assign forced_o  = expired;

  always_comb begin
    pending_d = pending_q;
    timer_d   = timer_q;
    if (start_i) begin
      pending_d = '1;
      timer_d   = '0;
    end else if (active_i) begin
      if (complete || expired) begin
        pending_d = '0;
        timer_d   = '0;
      end else begin
        pending_d = remaining;
        timer_d   = timer_q + timer_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      timer_q   <= '0;
    end else begin
      pending_q <= pending_d;
      timer_q   <= timer_d;
    end
  end

endmodule

// File: rtl/flush_sequencer.sv
// Sequences cache/TLB/pipeline flushes after fence-type instructions commit.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   fence_i_i         : fence.i commit pulse (icache + data channels + pipeline)
//   fence_i           : data fence commit pulse (data channels + pipeline)
//   sfence_vma_i      : sfence.vma commit pulse (TLB + pipeline)
//   flush_csr_i       : CSR side-effect pulse (pipeline only)
//   flush_ack_i       : per-channel flush-complete pulses
//   flush_req_o       : per-channel flush request level, held until acked
//   ack_pending_o     : channels still awaiting ack
//   halt_o, busy_o    : sequence active
//   flush_pipe_o, set_pc_commit_o, flush_icache_o, flush_tlb_o, timeout_o :
//                       one-cycle completion pulses in FINISH
// Every output is a decode of registered state.
module flush_sequencer
  import flush_seq_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned TIMEOUT = 512
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fence_i_i,
  input  logic              fence_i,
  input  logic              sfence_vma_i,
  input  logic              flush_csr_i,
  input  logic [NUM_CH-1:0] flush_ack_i,
  output logic [NUM_CH-1:0] flush_req_o,
  output logic [NUM_CH-1:0] ack_pending_o,
  output logic              halt_o,
  output logic              busy_o,
  output logic              flush_pipe_o,
  output logic              set_pc_commit_o,
  output logic              flush_icache_o,
  output logic              flush_tlb_o,
  output logic              timeout_o
);

  state_e            state_q, state_d;
  kind_t             flags_q, flags_d;
  logic              timeout_q, timeout_d;
  logic              start_flush, trk_done, trk_forced;
  logic [NUM_CH-1:0] pending;

  assign start_flush = (state_q == StIdle) && (fence_i_i || fence_i);

  flush_ack_tracker #(
    .NUM_CH  (NUM_CH),
    .TIMEOUT (TIMEOUT)
  ) u_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_flush),
    .active_i    (state_q == StFlush),
    .flush_ack_i (flush_ack_i),
    .pending_o   (pending),
    .done_o      (trk_done),
    .forced_o    (trk_forced)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      flags_q   <= KindNone;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic. Requests outside IDLE are dropped: commit is halted upstream.
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        flags_d   = decode_kind(fence_i_i, fence_i, sfence_vma_i);
        timeout_d = 1'b0;
        if (fence_i_i || fence_i) begin
          state_d = StFlush;
        end else if (sfence_vma_i || flush_csr_i) begin
          state_d = StFinish;
        end
      end
      StFlush: begin
        if (trk_done) begin
          state_d   = StFinish;
          timeout_d = trk_forced;
        end
      end
      StFinish: begin
        state_d   = StIdle;
        flags_d   = KindNone;
        timeout_d = 1'b0;
      end
      default: begin
        state_d   = StIdle;
        flags_d   = KindNone;
        timeout_d = 1'b0;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    flush_req_o     = '0;
    halt_o          = 1'b0;
    busy_o          = 1'b0;
    flush_pipe_o    = 1'b0;
    set_pc_commit_o = 1'b0;
    flush_icache_o  = 1'b0;
    flush_tlb_o     = 1'b0;
    timeout_o       = 1'b0;
    unique case (state_q)
      StFlush: begin
        halt_o = 1'b1;
        busy_o = 1'b1;
        // FLUSH is only entered for a data flush, so this gate is always open there.
        if (flags_q.dcache) begin
          flush_req_o = pending;
        end
      end
      StFinish: begin
        halt_o          = 1'b1;
        busy_o          = 1'b1;
        flush_pipe_o    = 1'b1;
        set_pc_commit_o = 1'b1;
        flush_icache_o  = flags_q.icache;
        flush_tlb_o     = flags_q.tlb;
        timeout_o       = timeout_q;
      end
      default: ;
    endcase
  end

  assign ack_pending_o = pending;

endmodule

// File: tb/tb_flush_sequencer.sv
module tb_flush_sequencer;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned TIMEOUT = 8;

  // Stimulus word: {fence_i_i, fence_i, sfence_vma_i, flush_csr_i, flush_ack[1:0]}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_FII  = 6'b100000;
  localparam logic [5:0] S_FI   = 6'b010000;
  localparam logic [5:0] S_SF   = 6'b001000;
  localparam logic [5:0] S_CSR  = 6'b000100;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              fence_i_i, fence_i, sfence_vma_i, flush_csr_i;
  logic [NUM_CH-1:0] flush_ack_i;
  logic [NUM_CH-1:0] flush_req_o, ack_pending_o;
  logic              halt_o, busy_o, flush_pipe_o, set_pc_commit_o;
  logic              flush_icache_o, flush_tlb_o, timeout_o;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs;

  flush_sequencer #(
    .NUM_CH  (NUM_CH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .fence_i_i       (fence_i_i),
    .fence_i         (fence_i),
    .sfence_vma_i    (sfence_vma_i),
    .flush_csr_i     (flush_csr_i),
    .flush_ack_i     (flush_ack_i),
    .flush_req_o     (flush_req_o),
    .ack_pending_o   (ack_pending_o),
    .halt_o          (halt_o),
    .busy_o          (busy_o),
    .flush_pipe_o    (flush_pipe_o),
    .set_pc_commit_o (set_pc_commit_o),
    .flush_icache_o  (flush_icache_o),
    .flush_tlb_o     (flush_tlb_o),
    .timeout_o       (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  // {flush_req, ack_pending, halt, busy, pipe, set_pc, icache, tlb, timeout}
  assign obs = {flush_req_o, ack_pending_o, halt_o, busy_o, flush_pipe_o, set_pc_commit_o,
                flush_icache_o, flush_tlb_o, timeout_o};

  function automatic logic [10:0] e_idle();
    return 11'b0;
  endfunction

  function automatic logic [10:0] e_flush(logic [1:0] p);
    return {p, p, 2'b11, 5'b00000};
  endfunction

  function automatic logic [10:0] e_fin(logic ic, logic tlb, logic to);
    return {2'b00, 2'b00, 2'b11, 2'b11, ic, tlb, to};
  endfunction

  task automatic drive(logic [5:0] s);
    {fence_i_i, fence_i, sfence_vma_i, flush_csr_i, flush_ack_i} = s;
  endtask

  task automatic test_reset();
    logic [10:0] want;
    drive(S_NONE);
    rst_i = 1'b1;
    exp_q.push_back(e_idle());
    @(posedge clk_i); #1;
    want = exp_q.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL reset got=%b want=%b", obs, want);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_sfence();
    logic [5:0]  st[$];
    logic [10:0] ex[$];
    logic [10:0] want;
    st = '{S_SF, S_NONE};
    ex = '{e_fin(1'b0, 1'b1, 1'b0), e_idle()};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk_i); #1;
      drive(S_NONE);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL sfence cyc%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_csr();
    logic [5:0]  st[$];
    logic [10:0] ex[$];
    logic [10:0] want;
    st = '{S_CSR, S_NONE};
    ex = '{e_fin(1'b0, 1'b0, 1'b0), e_idle()};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk_i); #1;
      drive(S_NONE);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL csr cyc%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_fence_i_acks();
    logic [5:0]  st[$];
    logic [10:0] ex[$];
    logic [10:0] want;
    st = '{S_FII, S_NONE, S_NONE | 6'b01, S_NONE, S_NONE | 6'b10, S_NONE};
    ex = '{e_flush(2'b11), e_flush(2'b11), e_flush(2'b10), e_flush(2'b10),
           e_fin(1'b1, 1'b0, 1'b0), e_idle()};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk_i); #1;
      drive(S_NONE);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL fence_i_acks cyc%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_timeout(logic tie);
    logic [5:0]  st[$];
    logic [10:0] ex[$];
    logic [10:0] want;
    st.push_back(S_FI);
    ex.push_back(e_flush(2'b11));
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
      st.push_back(S_NONE);
      ex.push_back(e_flush(2'b11));
    end
    // Last FLUSH cycle: either nothing (forced) or both acks (completion wins).
    st.push_back(tie ? (S_NONE | 6'b11) : S_NONE);
    ex.push_back(e_fin(1'b0, 1'b0, !tie));
    st.push_back(S_NONE);
    ex.push_back(e_idle());
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk_i); #1;
      drive(S_NONE);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL timeout tie=%0b cyc%0d got=%b want=%b", tie, i, obs, want);
      end
    end
  endtask

  task automatic test_combo();
    logic [5:0]  st[$];
    logic [10:0] ex[$];
    logic [10:0] want;
    st = '{S_FI | S_SF, S_NONE | 6'b11, S_NONE};
    ex = '{e_flush(2'b11), e_fin(1'b0, 1'b1, 1'b0), e_idle()};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk_i); #1;
      drive(S_NONE);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL combo cyc%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_ignore();
    logic [5:0]  st[$];
    logic [10:0] ex[$];
    logic [10:0] want;
    // Repeat ack on a cleared channel, requests during FLUSH/FINISH, acks in IDLE.
    st = '{S_FI, S_NONE | 6'b10, S_SF | S_FII | 6'b10, S_NONE | 6'b01, S_SF | S_FI,
           S_NONE | 6'b11, S_NONE};
    ex = '{e_flush(2'b11), e_flush(2'b01), e_flush(2'b01), e_fin(1'b0, 1'b0, 1'b0),
           e_idle(), e_idle(), e_idle()};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk_i); #1;
      drive(S_NONE);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL ignore cyc%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  st[$];
    logic [10:0] ex[$];
    logic [10:0] want;
    st = '{S_SF, S_FII, S_FII, S_NONE | 6'b11, S_CSR, S_NONE};
    ex = '{e_fin(1'b0, 1'b1, 1'b0), e_idle(), e_flush(2'b11), e_fin(1'b1, 1'b0, 1'b0),
           e_idle(), e_idle()};
    for (int i = 0; i < st.size(); i++) begin
      drive(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk_i); #1;
      drive(S_NONE);
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL back_to_back cyc%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [10:0] want;
    drive(S_FII);
    exp_q.push_back(e_flush(2'b11));
    @(posedge clk_i); #1;
    drive(S_NONE);
    want = exp_q.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL rst_mid enter got=%b want=%b", obs, want);
    end
    // Assert reset between edges: outputs must clear without a clock.
    #3;
    rst_i = 1'b1;
    exp_q.push_back(e_idle());
    #1;
    want = exp_q.pop_front();
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL rst_mid async got=%b want=%b", obs, want);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < int'(TIMEOUT) + 4; i++) begin
      exp_q.push_back(e_idle());
      @(posedge clk_i); #1;
      want = exp_q.pop_front();
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL rst_mid after cyc%0d got=%b want=%b", i, obs, want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(S_NONE);
    test_reset();
    test_sfence();
    test_csr();
    test_fence_i_acks();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_combo();
    test_ignore();
    test_back_to_back();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
